ifetch_unit: RTL

- Instruction fetch stage directly upstream of the instruction ROM.
- Owns the program counter and drives the ROM word address.
- Absorbs the ROM's one-cycle registered read latency.
- Presents instructions to decode through a valid/ready handshake, with a 2-entry buffer and redirect (branch/jump/jal/jr) flush.

---
 rtl/ifetch_unit.sv | 122 ++++++++++++
 1 files changed

// File: rtl/ifetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : ifetch_unit
// Brief    : Instruction fetch stage: owns the PC, absorbs the one-cycle ROM
//            latency and feeds decode via a 2-entry valid/ready buffer with
//            redirect flush. Optional macro IF_PERF_CNT_EN adds fetch/flush
//            counters.
// Revision : 1.0 - initial release
// ============================================================================
module ifetch_unit #(
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 32,
    parameter int RESET_PC = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [DATA_W-1:0] imem_data,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [DATA_W-1:0] inst,
    output logic [ADDR_W-1:0] inst_pc,
    output logic [ADDR_W-1:0] inst_pc_plus1
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0]       fetch_cnt,
    output logic [15:0]       flush_cnt
`endif
);

    localparam logic [ADDR_W-1:0] c_reset_pc = ADDR_W'(RESET_PC);

    logic [ADDR_W-1:0] r_fpc;
    logic [ADDR_W-1:0] r_req_pc;
    logic              r_inflight;
    logic [ADDR_W-1:0] r_buf_pc   [2];
    logic [DATA_W-1:0] r_buf_inst [2];
    logic              r_wptr;
    logic              r_rptr;
    logic [1:0]        r_count;

    logic              w_pop;
    logic              w_push;
    logic              w_issue;
    logic [2:0]        w_occ;
    logic              w_head;

    assign w_pop   = inst_valid & inst_ready;
    assign w_push  = r_inflight & ~redirect_valid;
    // Slots still committed after this edge; a new read may only be issued
    // if its data is guaranteed a free entry when it lands.
    assign w_occ   = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_pop};
    assign w_issue = ~redirect_valid & (w_occ < 3'd2);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_fpc      <= c_reset_pc;
            r_req_pc   <= c_reset_pc;
            r_inflight <= 1'b0;
            r_count    <= 2'd0;
            r_wptr     <= 1'b0;
            r_rptr     <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                r_buf_pc[i]   <= '0;
                r_buf_inst[i] <= '0;
            end
        end else if (redirect_valid) begin
            r_fpc      <= redirect_pc;
            r_inflight <= 1'b0;
            r_count    <= 2'd0;
            r_wptr     <= r_rptr;
        end else begin
            if (w_issue) begin
                r_fpc      <= r_fpc + ADDR_W'(1);
                r_req_pc   <= r_fpc;
                r_inflight <= 1'b1;
            end else begin
                r_inflight <= 1'b0;
            end
            if (w_push) begin
                r_buf_pc[r_wptr]   <= r_req_pc;
                r_buf_inst[r_wptr] <= imem_data;
                r_wptr             <= ~r_wptr;
            end
            if (w_pop) begin
                r_rptr <= ~r_rptr;
            end
            r_count <= r_count + 2'(w_push) - 2'(w_pop);
        end
    end

    // When empty, point at the entry popped last so the outputs hold.
    assign w_head        = (r_count == 2'd0) ? ~r_rptr : r_rptr;
    assign imem_addr     = r_fpc;
    assign inst_valid    = (r_count != 2'd0);
    assign inst          = r_buf_inst[w_head];
    assign inst_pc       = r_buf_pc[w_head];
    assign inst_pc_plus1 = inst_pc + ADDR_W'(1);

`ifdef IF_PERF_CNT_EN
    logic [31:0] r_fetch_cnt;
    logic [15:0] r_flush_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_fetch_cnt <= 32'd0;
            r_flush_cnt <= 16'd0;
        end else if (redirect_valid) begin
            r_flush_cnt <= r_flush_cnt + 16'd1;
        end else if (w_pop) begin
            r_fetch_cnt <= r_fetch_cnt + 32'd1;
        end
    end

    assign fetch_cnt = r_fetch_cnt;
    assign flush_cnt = r_flush_cnt;
`endif

endmodule
`default_nettype wire
